loop_stack: RTL and testbench
=============================

Name: loop_stack

Overview:
Memory-side responder for the fetch unit's PC save/restore byte protocol. It receives a program counter as two consecutive byte beats from the fetch unit's store path and pushes it onto an internal LIFO of loop-start addresses. On request, it returns the top entry as two byte beats for the fetch unit's load path, either popping it or leaving it in place (peek). It sits between fetch_unit and the data-memory byte bus and supports nested-loop jump-back in the BeeF core.

Parameters:
DEPTH, 16, number of PROGRAM_COUNTER entries; power of two, at least 2.
PTR_W, $clog2(DEPTH), stack pointer width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  store beat valid
wr_byte  input  8 (BYTE)  store beat data; low byte first, then high byte
rd_req  input  1  read request, level; held by requester until the first rd_valid
rd_pop  input  1  sampled with an accepted rd_req; 1 = pop after read, 0 = peek
drop  input  1  discard the top entry without reading it
rd_valid  output  1  return beat valid
rd_byte  output  8 (BYTE)  return beat data; low byte, then high byte
busy  output  1  state != IDLE
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  PTR_W+1  number of stored entries
err_overflow  output  1  sticky; push attempted while full
err_underflow  output  1  sticky; read or drop attempted while empty

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, count=0, rd_valid=0, rd_byte=8'h00, both err flags=0. Storage contents are not reset.
- FSM states: IDLE, WR_HI, RD_LO, RD_HI.
- IDLE, priority wr_valid > rd_req > drop:
  - wr_valid: latch wr_byte as the low byte and go to WR_HI.
  - rd_req with wr_valid=0: latch rd_pop and the top entry (or 16'h0000 if empty) and go to RD_LO.
  - drop with no other request: if count>0, decrement count; else set err_underflow. State stays IDLE.
- WR_HI:
  - Waits for the next wr_valid; gaps between beats are allowed.
  - On wr_valid: form {wr_byte, low}. If not full, write it at index count and increment count; else set err_overflow and discard the entry. Return to IDLE.
  - rd_req and drop are ignored in this state.
- RD_LO: rd_valid=1, rd_byte=latched[7:0], go to RD_HI.
- RD_HI:
  - rd_valid=1, rd_byte=latched[15:8], return to IDLE.
  - At this edge: if the latched pop flag is set and count>0, decrement count.
  - If the stack was empty at acceptance, set err_underflow at acceptance; both beats still return 8'h00 so the loader never hangs.
- Read latency: rd_req accepted at edge N gives the low beat during cycle N+1 and the high beat during cycle N+2. The next request can be accepted at the N+2 edge (back-to-back allowed).
- Write: the second beat edge updates count; full/empty/count reflect it in the next cycle.
- Peek returns the same value on every repeat with count unchanged.
- rd_valid and rd_byte are registered outputs. rd_byte holds its last value when rd_valid=0.
- Error flags clear only on reset.
- Reset mid-transfer aborts the transfer immediately, with no partial push and no rd_valid.
- Order is LIFO. The top entry is at index count-1. Pointer arithmetic never wraps: it is guarded by full/empty.

Decomposition:
- definitions package: the existing BYTE and PROGRAM_COUNTER types, plus a new typedef enum logic [1:0] loop_stack_state_t {LS_IDLE, LS_WR_HI, LS_RD_LO, LS_RD_HI}.
- One sub-module: loop_stack_mem, a DEPTH x 16 register array with one synchronous write port and one asynchronous read port at index count-1.
- FSM and counters stay in loop_stack.

Test Plan:
1. Reset, then push 16'h1234 as beats 8'h34, 8'h12, then rd_req with rd_pop=1 -> rd_byte 8'h34 then 8'h12 on consecutive cycles; count 1->0; empty=1.
2. Push 16'h0010, 16'h0020, 16'h0030; peek twice, then pop three times -> peeks return 0x0030 both times with count=3; pops return 0x0030, 0x0020, 0x0010.
3. Fill DEPTH entries (0..15), push 16'hBEEF -> full=1, err_overflow=1, count=16; a following pop returns 0x000F.
4. Empty stack: rd_req, then drop -> two beats of 8'h00, err_underflow=1, count stays 0.
5. wr_valid and rd_req asserted together in IDLE, with a 3-cycle gap between write beats -> write completes first and busy=1 during the gap; the read starts on the cycle after the write completes and returns the newly pushed value.
6. rst_n pulled low between the two write beats and again between RD_LO and RD_HI -> count=0, no rd_valid, state IDLE, error flags cleared.

Source files
------------

// File: rtl/loop_stack_pkg.sv
// Shared types for the loop-start stack: byte/PC beats and the transfer FSM states.
package loop_stack_pkg;

  typedef logic [7:0]  BYTE;
  typedef logic [15:0] PROGRAM_COUNTER;

  typedef enum logic [1:0] {
    LS_IDLE  = 2'd0,
    LS_WR_HI = 2'd1,
    LS_RD_LO = 2'd2,
    LS_RD_HI = 2'd3
  } loop_stack_state_t;

  // Low beat of a program counter (sent first on the byte bus).
  function automatic BYTE pc_lo(input PROGRAM_COUNTER pc);
    return pc[7:0];
  endfunction

  // High beat of a program counter (sent second on the byte bus).
  function automatic BYTE pc_hi(input PROGRAM_COUNTER pc);
    return pc[15:8];
  endfunction

endpackage

// File: rtl/loop_stack_mem.sv
// DEPTH x 16 storage for saved loop-start addresses: one synchronous write
// port, one asynchronous read port. Contents are deliberately not reset.
module loop_stack_mem
  import loop_stack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [15:0]      wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [15:0]      rdata
);

  PROGRAM_COUNTER mem_r [DEPTH];

  // Store a completed push at the slot just above the current top.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/loop_stack.sv
// Loop-start LIFO responder: collects a PC as two store beats and returns the
// top entry as two load beats, with pop/peek, drop and sticky error flags.
module loop_stack
  import loop_stack_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_valid,
  input  logic [7:0]     wr_byte,
  input  logic           rd_req,
  input  logic           rd_pop,
  input  logic           drop,
  output logic           rd_valid,
  output logic [7:0]     rd_byte,
  output logic           busy,
  output logic           empty,
  output logic           full,
  output logic [PTR_W:0] count,
  output logic           err_overflow,
  output logic           err_underflow
);

  localparam logic [PTR_W:0] CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  loop_stack_state_t state_r;
  logic [PTR_W:0]    count_r;
  BYTE               low_r;
  PROGRAM_COUNTER    data_r;
  logic              pop_r;
  logic              rd_valid_r;
  BYTE               rd_byte_r;
  logic              err_ov_r;
  logic              err_un_r;

  logic [PTR_W:0]    count_eff_s;
  logic [PTR_W-1:0]  top_idx_s;
  PROGRAM_COUNTER    rdata_s;
  PROGRAM_COUNTER    top_s;
  logic              full_s;
  logic              empty_s;
  logic              arb_s;
  logic              start_wr_s;
  logic              start_rd_s;
  logic              drop_s;
  logic              we_s;

  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);

  // Count as seen by a read accepted this cycle: a pop finishing in RD_HI is
  // already applied so back-to-back reads see the new top.
  always_comb begin
    count_eff_s = count_r;
    if (state_r == LS_RD_HI && pop_r && !empty_s) begin
      count_eff_s = count_r - CNT_ONE;
    end else begin
      count_eff_s = count_r;
    end
  end

  // Top-of-stack value; an empty stack reads as zero so the loader never hangs.
  always_comb begin
    top_idx_s = PTR_W'(count_eff_s - CNT_ONE);
    if (count_eff_s == CNT_ZERO) begin
      top_s = 16'h0000;
    end else begin
      top_s = rdata_s;
    end
  end

  // New transfers are arbitrated in IDLE and also on the final read beat,
  // with priority write > read > drop.
  always_comb begin
    arb_s      = (state_r == LS_IDLE) || (state_r == LS_RD_HI);
    start_wr_s = arb_s && wr_valid;
    start_rd_s = arb_s && !wr_valid && rd_req;
    drop_s     = (state_r == LS_IDLE) && !wr_valid && !rd_req && drop;
    we_s       = (state_r == LS_WR_HI) && wr_valid && !full_s;
  end

  loop_stack_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (count_r[PTR_W-1:0]),
    .wdata ({wr_byte, low_r}),
    .raddr (top_idx_s),
    .rdata (rdata_s)
  );

  // Transfer FSM with pointer, latched read data, registered beats and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= LS_IDLE;
      count_r    <= CNT_ZERO;
      low_r      <= 8'h00;
      data_r     <= 16'h0000;
      pop_r      <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_byte_r  <= 8'h00;
      err_ov_r   <= 1'b0;
      err_un_r   <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      case (state_r)
        LS_IDLE: begin
          state_r <= LS_IDLE;
        end
        LS_WR_HI: begin
          if (wr_valid) begin
            if (!full_s) begin
              count_r <= count_r + CNT_ONE;
            end else begin
              err_ov_r <= 1'b1;
            end
            state_r <= LS_IDLE;
          end else begin
            state_r <= LS_WR_HI;
          end
        end
        LS_RD_LO: begin
          rd_valid_r <= 1'b1;
          rd_byte_r  <= pc_hi(data_r);
          state_r    <= LS_RD_HI;
        end
        LS_RD_HI: begin
          count_r <= count_eff_s;
          state_r <= LS_IDLE;
        end
        default: begin
          state_r <= LS_IDLE;
        end
      endcase

      if (start_wr_s) begin
        low_r   <= wr_byte;
        state_r <= LS_WR_HI;
      end else if (start_rd_s) begin
        pop_r      <= rd_pop;
        data_r     <= top_s;
        rd_valid_r <= 1'b1;
        rd_byte_r  <= pc_lo(top_s);
        if (count_eff_s == CNT_ZERO) begin
          err_un_r <= 1'b1;
        end
        state_r <= LS_RD_LO;
      end else if (drop_s) begin
        if (!empty_s) begin
          count_r <= count_r - CNT_ONE;
        end else begin
          err_un_r <= 1'b1;
        end
      end else begin
        low_r <= low_r;
      end
    end
  end

  assign rd_valid      = rd_valid_r;
  assign rd_byte       = rd_byte_r;
  assign busy          = (state_r != LS_IDLE);
  assign empty         = empty_s;
  assign full          = full_s;
  assign count         = count_r;
  assign err_overflow  = err_ov_r;
  assign err_underflow = err_un_r;

endmodule

// File: tb/tb_loop_stack.sv
// Scoreboard bench for loop_stack: a queue-based LIFO model predicts return
// beats and status; a negedge monitor compares every rd_valid beat.
module tb_loop_stack;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       rd_req = 1'b0;
  logic       rd_pop = 1'b0;
  logic       drop = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_byte;
  logic       busy, empty, full;
  logic [4:0] count;
  logic       err_overflow, err_underflow;

  loop_stack #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_byte       (wr_byte),
    .rd_req        (rd_req),
    .rd_pop        (rd_pop),
    .drop          (drop),
    .rd_valid      (rd_valid),
    .rd_byte       (rd_byte),
    .busy          (busy),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model_q [$];   // element 0 is the bottom of the stack
  logic        model_ov = 1'b0;
  logic        model_un = 1'b0;
  logic [7:0]  model_last = 8'h00;
  logic [7:0]  exp_q [$];     // expected return beats in order
  bit          last_was_read = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every presented beat must match the next predicted one.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got rd_valid=1 byte 0x%0h, expected no beat at %0t", rd_byte, $time);
      end else begin
        check("rd_byte", 32'(rd_byte), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
    last_was_read = 1'b0;
  endtask

  task automatic quiet_check(input string tag);
    check({tag, "_count"}, 32'(count), 32'(model_q.size()));
    check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(model_q.size() == DEPTH));
    check({tag, "_err_ov"}, 32'(err_overflow), 32'(model_ov));
    check({tag, "_err_un"}, 32'(err_underflow), 32'(model_un));
    check({tag, "_rd_byte_hold"}, 32'(rd_byte), 32'(model_last));
  endtask

  task automatic push(input logic [15:0] pc, input int gap, input bit do_check);
    wait_idle();
    wr_valid = 1'b1;
    wr_byte  = pc[7:0];
    @(negedge clk);
    wr_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      check("busy_in_gap", 32'(busy), 32'd1);
      @(negedge clk);
    end
    wr_valid = 1'b1;
    wr_byte  = pc[15:8];
    @(negedge clk);
    wr_valid = 1'b0;
    if (model_q.size() == DEPTH) model_ov = 1'b1;
    else model_q.push_back(pc);
    if (do_check) quiet_check("push");
  endtask

  // Model the read at issue time, then hold rd_req until the first beat.
  task automatic read(input logic pop);
    logic [15:0] v;
    int n;
    if (last_was_read) @(negedge clk);
    if (model_q.size() == 0) begin
      v = 16'h0000;
      model_un = 1'b1;
    end else begin
      v = model_q[model_q.size()-1];
      if (pop) void'(model_q.pop_back());
    end
    exp_q.push_back(v[7:0]);
    exp_q.push_back(v[15:8]);
    model_last = v[15:8];
    rd_req = 1'b1;
    rd_pop = pop;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd_valid !== 1'b1 && n < 20);
    rd_req = 1'b0;
    rd_pop = 1'b0;
    if (rd_valid !== 1'b1) check("read_timeout", 32'(rd_valid), 32'd1);
    last_was_read = 1'b1;
  endtask

  task automatic do_drop();
    wait_idle();
    drop = 1'b1;
    @(negedge clk);
    drop = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_back());
    else model_un = 1'b1;
    quiet_check("drop");
  endtask

  task automatic settle(input string tag);
    wait_idle();
    quiet_check(tag);
  endtask

  // Asynchronous reset a little after the falling edge; outputs must clear at once.
  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    wr_valid = 1'b0;
    rd_req = 1'b0;
    rd_pop = 1'b0;
    drop = 1'b0;
    model_q.delete();
    exp_q.delete();
    model_ov = 1'b0;
    model_un = 1'b0;
    model_last = 8'h00;
    last_was_read = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_ov", 32'(err_overflow), 32'd0);
    check("rst_err_un", 32'(err_underflow), 32'd0);
    check("rst_rd_byte", 32'(rd_byte), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [15:0] pc;
    int op;

    @(negedge clk);
    apply_reset();
    quiet_check("reset");

    // Single push then pop.
    push(16'h1234, 0, 1'b1);
    read(1'b1);
    settle("t1");

    // Nested pushes, repeated peeks, then LIFO pops (back-to-back reads).
    push(16'h0010, 1, 1'b1);
    push(16'h0020, 0, 1'b1);
    push(16'h0030, 2, 1'b1);
    read(1'b0);
    read(1'b0);
    settle("t2_peek");
    read(1'b1);
    read(1'b1);
    read(1'b1);
    settle("t2_pop");

    // Fill, overflow, then pop the real top.
    for (int i = 0; i < DEPTH; i++) push(16'(i), 0, 1'b0);
    settle("t3_filled");
    push(16'hBEEF, 0, 1'b1);
    read(1'b1);
    settle("t3_pop");

    apply_reset();

    // Underflow on read and on drop.
    read(1'b1);
    settle("t4_read");
    do_drop();

    // Write and read requested together; write wins, read follows.
    wait_idle();
    wr_valid = 1'b1;
    wr_byte  = 8'h78;
    rd_req   = 1'b1;
    rd_pop   = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check("t5_busy_gap", 32'(busy), 32'd1);
      check("t5_no_rd_in_gap", 32'(rd_valid), 32'd0);
      @(negedge clk);
    end
    wr_valid = 1'b1;
    wr_byte  = 8'h56;
    @(negedge clk);
    wr_valid = 1'b0;
    model_q.push_back(16'h5678);
    void'(model_q.pop_back());
    exp_q.push_back(8'h78);
    exp_q.push_back(8'h56);
    model_last = 8'h56;
    check("t5_rd_after_wr_cycle1", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("t5_rd_after_wr_cycle2", 32'(rd_valid), 32'd1);
    rd_req = 1'b0;
    rd_pop = 1'b0;
    settle("t5");

    // Reset between write beats.
    push(16'h4242, 0, 1'b0);
    wait_idle();
    wr_valid = 1'b1;
    wr_byte  = 8'h11;
    @(negedge clk);
    wr_valid = 1'b0;
    check("t6_busy_mid_write", 32'(busy), 32'd1);
    apply_reset();
    quiet_check("t6_after_wr_reset");

    // Reset between the low and high read beats.
    push(16'hA55A, 0, 1'b0);
    exp_q.push_back(8'h5A);
    rd_req = 1'b1;
    rd_pop = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd_valid !== 1'b1 && n < 20);
    rd_req = 1'b0;
    rd_pop = 1'b0;
    check("t6_low_beat_seen", 32'(rd_valid), 32'd1);
    apply_reset();
    repeat (3) @(negedge clk);
    quiet_check("t6_after_rd_reset");

    // Randomized mix against the LIFO model.
    for (int k = 0; k < 400; k++) begin
      op = int'($urandom_range(0, 9));
      pc = 16'($urandom);
      case (op)
        0, 1, 2, 3: push(pc, int'($urandom_range(0, 2)), 1'b1);
        4, 5:       read(1'b1);
        6, 7:       read(1'b0);
        8:          do_drop();
        default:    settle("rand_idle");
      endcase
    end

    settle("final");
    repeat (3) @(negedge clk);
    check("pending_beats", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
